// File: rtl/main_mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, requester ids and
// default widths.
package main_mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int GRANT_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LD = 2'd1,
        EXEC_LD  = 2'd2,
        EXEC_ST  = 2'd3
    } arb_state_t;

    typedef enum logic [GRANT_W-1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } arb_id_t;

endpackage

// File: rtl/main_mem_arb_pick.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen; a lone requester always wins.
module main_mem_arb_pick
    import main_mem_arb_pkg::*;
(
    input  logic    fetch_req,
    input  logic    exec_req,
    input  arb_id_t last_winner,
    output arb_id_t winner
);

    always_comb begin
        winner = NONE;
        if (fetch_req && exec_req) begin
            winner = (last_winner == FETCH) ? EXEC : FETCH;
        end else if (fetch_req) begin
            winner = FETCH;
        end else if (exec_req) begin
            winner = EXEC;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between instruction fetch (loads) and the
// memory execution element (loads and stores), one transaction at a time.
module main_mem_arbiter
    import main_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_mem_out_addr,
    input  logic              fetch_mem_out_valid,
    output logic              fetch_mem_out_ready,
    output logic [DATA_W-1:0] fetch_mem_out_data,
    input  logic [ADDR_W-1:0] exec_mem_out_addr,
    input  logic              exec_mem_out_valid,
    output logic              exec_mem_out_ready,
    output logic [DATA_W-1:0] exec_mem_out_data,
    input  logic [ADDR_W-1:0] exec_mem_in_addr,
    input  logic [DATA_W-1:0] exec_mem_in_data,
    input  logic              exec_mem_in_valid,
    output logic              exec_mem_in_ready,
    output logic [ADDR_W-1:0] main_mem_out_addr,
    output logic              main_mem_out_valid,
    input  logic              main_mem_out_ready,
    input  logic [DATA_W-1:0] main_mem_out_data,
    output logic [ADDR_W-1:0] main_mem_in_addr,
    output logic [DATA_W-1:0] main_mem_in_data,
    output logic              main_mem_in_valid,
    input  logic              main_mem_in_ready,
    output logic [1:0]        grant_id
);

    arb_state_t        state_reg, state_next;
    arb_id_t           last_winner_reg, last_winner_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    arb_id_t           winner;

    main_mem_arb_pick u_pick (
        .fetch_req   (fetch_mem_out_valid),
        .exec_req    (exec_mem_out_valid | exec_mem_in_valid),
        .last_winner (last_winner_reg),
        .winner      (winner)
    );

    // last_winner starts at EXEC so fetch takes the first tie after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_winner_reg <= EXEC;
            addr_reg        <= '0;
            data_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            last_winner_reg <= last_winner_next;
            addr_reg        <= addr_next;
            data_reg        <= data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_winner_next = last_winner_reg;
        addr_next        = addr_reg;
        data_next        = data_reg;
        case (state_reg)
            IDLE: begin
                if (winner == FETCH) begin
                    state_next = FETCH_LD;
                    addr_next  = fetch_mem_out_addr;
                    data_next  = '0;
                end else if (winner == EXEC) begin
                    // a pending store beats a pending load from the same unit
                    if (exec_mem_in_valid) begin
                        state_next = EXEC_ST;
                        addr_next  = exec_mem_in_addr;
                        data_next  = exec_mem_in_data;
                    end else begin
                        state_next = EXEC_LD;
                        addr_next  = exec_mem_out_addr;
                        data_next  = '0;
                    end
                end
            end
            FETCH_LD: begin
                if (main_mem_out_ready) begin
                    state_next       = IDLE;
                    last_winner_next = FETCH;
                end
            end
            EXEC_LD: begin
                if (main_mem_out_ready) begin
                    state_next       = IDLE;
                    last_winner_next = EXEC;
                end
            end
            EXEC_ST: begin
                if (main_mem_in_ready) begin
                    state_next       = IDLE;
                    last_winner_next = EXEC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        main_mem_out_addr   = '0;
        main_mem_out_valid  = 1'b0;
        main_mem_in_addr    = '0;
        main_mem_in_data    = '0;
        main_mem_in_valid   = 1'b0;
        fetch_mem_out_ready = 1'b0;
        fetch_mem_out_data  = '0;
        exec_mem_out_ready  = 1'b0;
        exec_mem_out_data   = '0;
        exec_mem_in_ready   = 1'b0;
        grant_id            = NONE;
        case (state_reg)
            FETCH_LD: begin
                grant_id            = FETCH;
                main_mem_out_valid  = 1'b1;
                main_mem_out_addr   = addr_reg;
                fetch_mem_out_ready = main_mem_out_ready;
                fetch_mem_out_data  = main_mem_out_ready ? main_mem_out_data : '0;
            end
            EXEC_LD: begin
                grant_id           = EXEC;
                main_mem_out_valid = 1'b1;
                main_mem_out_addr  = addr_reg;
                exec_mem_out_ready = main_mem_out_ready;
                exec_mem_out_data  = main_mem_out_ready ? main_mem_out_data : '0;
            end
            EXEC_ST: begin
                grant_id          = EXEC;
                main_mem_in_valid = 1'b1;
                main_mem_in_addr  = addr_reg;
                main_mem_in_data  = data_reg;
                exec_mem_in_ready = main_mem_in_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: vector table of request mixes,
// a scoreboard of expected completions, and hand-written corner sequences.
module tb_main_mem_arbiter;

    typedef struct {
        bit          f_v;
        logic [31:0] f_addr;
        bit          el_v;
        logic [31:0] el_addr;
        bit          es_v;
        logic [31:0] es_addr;
        logic [31:0] es_data;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  exp_grant;
    } vec_t;

    // kind: 1 fetch load, 2 exec load, 3 exec store
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_mem_out_addr;
    logic        fetch_mem_out_valid;
    logic        fetch_mem_out_ready;
    logic [31:0] fetch_mem_out_data;
    logic [31:0] exec_mem_out_addr;
    logic        exec_mem_out_valid;
    logic        exec_mem_out_ready;
    logic [31:0] exec_mem_out_data;
    logic [31:0] exec_mem_in_addr;
    logic [31:0] exec_mem_in_data;
    logic        exec_mem_in_valid;
    logic        exec_mem_in_ready;
    logic [31:0] main_mem_out_addr;
    logic        main_mem_out_valid;
    logic        main_mem_out_ready;
    logic [31:0] main_mem_out_data;
    logic [31:0] main_mem_in_addr;
    logic [31:0] main_mem_in_data;
    logic        main_mem_in_valid;
    logic        main_mem_in_ready;
    logic [1:0]  grant_id;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   model_last = 2;

    int          mem_delay = 0;
    int          mem_cnt   = 0;
    bit          mem_rdy   = 1'b0;
    bit          stray     = 1'b0;
    logic [31:0] mem_data  = 32'h0;

    main_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_mem_out_addr  (fetch_mem_out_addr),
        .fetch_mem_out_valid (fetch_mem_out_valid),
        .fetch_mem_out_ready (fetch_mem_out_ready),
        .fetch_mem_out_data  (fetch_mem_out_data),
        .exec_mem_out_addr   (exec_mem_out_addr),
        .exec_mem_out_valid  (exec_mem_out_valid),
        .exec_mem_out_ready  (exec_mem_out_ready),
        .exec_mem_out_data   (exec_mem_out_data),
        .exec_mem_in_addr    (exec_mem_in_addr),
        .exec_mem_in_data    (exec_mem_in_data),
        .exec_mem_in_valid   (exec_mem_in_valid),
        .exec_mem_in_ready   (exec_mem_in_ready),
        .main_mem_out_addr   (main_mem_out_addr),
        .main_mem_out_valid  (main_mem_out_valid),
        .main_mem_out_ready  (main_mem_out_ready),
        .main_mem_out_data   (main_mem_out_data),
        .main_mem_in_addr    (main_mem_in_addr),
        .main_mem_in_data    (main_mem_in_data),
        .main_mem_in_valid   (main_mem_in_valid),
        .main_mem_in_ready   (main_mem_in_ready),
        .grant_id            (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // memory model: answers `mem_delay` cycles after a valid appears; data is
    // garbage whenever ready is low so output gating gets exercised
    initial begin
        main_mem_out_ready = 1'b0;
        main_mem_in_ready  = 1'b0;
        main_mem_out_data  = 32'hBAD0_BAD0;
    end
    always begin
        @(posedge clk);
        #1;
        if (main_mem_out_valid || main_mem_in_valid) begin
            if (mem_cnt >= mem_delay) begin
                mem_rdy = 1'b1;
            end else begin
                mem_rdy = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_rdy = 1'b0;
            mem_cnt = 0;
        end
        main_mem_out_ready = (mem_rdy && main_mem_out_valid) || stray;
        main_mem_in_ready  = (mem_rdy && main_mem_in_valid) || stray;
        main_mem_out_data  = main_mem_out_ready ? mem_data : 32'hBAD0_BAD0;
    end

    // scoreboard monitor
    exp_t mon_e;
    int   mon_nr;
    int   mon_gid;
    always @(negedge clk) begin
        if (reset) begin
            mon_nr = int'(fetch_mem_out_ready) + int'(exec_mem_out_ready) + int'(exec_mem_in_ready);
            chk("load_data_gated",
                int'((!fetch_mem_out_ready && fetch_mem_out_data != 0) ||
                     (!exec_mem_out_ready && exec_mem_out_data != 0)), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_activity", int'(mon_nr != 0 || grant_id != 0), 0);
            end else begin
                mon_e   = sb_q[0];
                mon_gid = (mon_e.kind == 1) ? 1 : 2;
                if (grant_id != 0) begin
                    chk("grant_owner", 32'(grant_id), mon_gid);
                    if (mon_e.kind == 3) begin
                        chk("store_downstream",
                            int'(main_mem_in_valid && !main_mem_out_valid &&
                                 main_mem_in_addr == mon_e.addr && main_mem_in_data == mon_e.data), 1);
                    end else begin
                        chk("load_downstream",
                            int'(main_mem_out_valid && !main_mem_in_valid &&
                                 main_mem_out_addr == mon_e.addr), 1);
                    end
                end else begin
                    chk("idle_quiet", int'(mon_nr != 0 || main_mem_out_valid || main_mem_in_valid), 0);
                end
                if (mon_nr != 0) begin
                    case (mon_e.kind)
                        1: chk("fetch_done", int'(fetch_mem_out_ready && mon_nr == 1 &&
                                                  fetch_mem_out_data == mon_e.data), 1);
                        2: chk("exec_ld_done", int'(exec_mem_out_ready && mon_nr == 1 &&
                                                    exec_mem_out_data == mon_e.data), 1);
                        default: chk("exec_st_done", int'(exec_mem_in_ready && mon_nr == 1), 1);
                    endcase
                    $display("txn kind=%0d addr=%h data=%h done at %0t", mon_e.kind, mon_e.addr, mon_e.data, $time);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit pf, pl, ps;
        int n;
        int done;
        @(posedge clk);
        #1;
        mem_delay           = v.delay;
        mem_data            = v.rdata;
        fetch_mem_out_valid = v.f_v;
        fetch_mem_out_addr  = v.f_addr;
        exec_mem_out_valid  = v.el_v;
        exec_mem_out_addr   = v.el_addr;
        exec_mem_in_valid   = v.es_v;
        exec_mem_in_addr    = v.es_addr;
        exec_mem_in_data    = v.es_data;
        // predicted completion order for requests that are all held from now
        pf = v.f_v; pl = v.el_v; ps = v.es_v; n = 0;
        while (pf || pl || ps) begin
            if (pf && (!(pl || ps) || model_last == 2)) begin
                push_exp(1, v.f_addr, v.rdata);
                pf = 1'b0;
                model_last = 1;
            end else if (ps) begin
                push_exp(3, v.es_addr, v.es_data);
                ps = 1'b0;
                model_last = 2;
            end else begin
                push_exp(2, v.el_addr, v.rdata);
                pl = 1'b0;
                model_last = 2;
            end
            n++;
        end
        @(posedge clk);
        done = 0;
        for (int g = 0; g < 60 && done < n; g++) begin
            @(negedge clk);
            if (g == 0) chk($sformatf("vec%0d_first_grant", idx), 32'(grant_id), 32'(v.exp_grant));
            if (fetch_mem_out_ready) begin fetch_mem_out_valid = 1'b0; done++; end
            if (exec_mem_out_ready)  begin exec_mem_out_valid  = 1'b0; done++; end
            if (exec_mem_in_ready)   begin exec_mem_in_valid   = 1'b0; done++; end
        end
        chk($sformatf("vec%0d_completions", idx), done, n);
    endtask

    vec_t vecs[9];
    vec_t post_vec;
    int   gseq[8];

    initial begin
        vecs[0] = '{1'b1, 32'h1000, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        0, 32'hDEADBEEF, 2'd1};
        vecs[1] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h10f4, 32'h12345678, 2, 32'h0,        2'd2};
        vecs[2] = '{1'b0, 32'h0,    1'b1, 32'h2200, 1'b1, 32'h2204, 32'hCAFEF00D, 3, 32'h0BADF00D, 2'd2};
        vecs[3] = '{1'b1, 32'h1100, 1'b1, 32'h2300, 1'b0, 32'h0,    32'h0,        0, 32'h11112222, 2'd1};
        vecs[4] = '{1'b1, 32'h1200, 1'b1, 32'h2400, 1'b1, 32'h2404, 32'h87654321, 1, 32'h33334444, 2'd1};
        vecs[5] = '{1'b0, 32'h0,    1'b1, 32'h2000, 1'b0, 32'h0,    32'h0,        0, 32'h55556666, 2'd2};
        vecs[6] = '{1'b1, 32'h3000, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        2, 32'h77778888, 2'd1};
        vecs[7] = '{1'b1, 32'h3100, 1'b0, 32'h0,    1'b1, 32'h3104, 32'h9999AAAA, 0, 32'hBBBBCCCC, 2'd2};
        vecs[8] = '{1'b1, 32'h3200, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        0, 32'hDDDDEEEE, 2'd1};
        post_vec = '{1'b1, 32'h6000, 1'b1, 32'h6100, 1'b0, 32'h0, 32'h0, 0, 32'h01234567, 2'd1};
        gseq = '{1, 0, 2, 0, 1, 0, 2, 0};

        reset = 1'b0;
        fetch_mem_out_addr = '0; fetch_mem_out_valid = 1'b0;
        exec_mem_out_addr  = '0; exec_mem_out_valid  = 1'b0;
        exec_mem_in_addr   = '0; exec_mem_in_data    = '0; exec_mem_in_valid = 1'b0;
        #2;
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_valids", 32'({main_mem_out_valid, main_mem_in_valid}), 0);
        chk("rst_readies", 32'({fetch_mem_out_ready, exec_mem_out_ready, exec_mem_in_ready}), 0);
        chk("rst_addr_data", main_mem_out_addr | main_mem_in_addr | main_mem_in_data |
                             fetch_mem_out_data | exec_mem_out_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // both load requesters held high, memory always ready
        @(posedge clk);
        #1;
        mem_delay = 0;
        mem_data  = 32'h5555_AAAA;
        fetch_mem_out_valid = 1'b1; fetch_mem_out_addr = 32'h4000;
        exec_mem_out_valid  = 1'b1; exec_mem_out_addr  = 32'h4100;
        for (int i = 0; i < 2; i++) begin
            push_exp(1, 32'h4000, 32'h5555_AAAA);
            push_exp(2, 32'h4100, 32'h5555_AAAA);
        end
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("stream_grant%0d", i), 32'(grant_id), gseq[i]);
        end
        fetch_mem_out_valid = 1'b0;
        exec_mem_out_valid  = 1'b0;
        model_last = 2;
        repeat (2) @(negedge clk);
        chk("stream_drained", sb_q.size(), 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // downstream ready while nothing is granted must be ignored
        @(negedge clk);
        stray = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stray_ready_ignored",
            32'({fetch_mem_out_ready, exec_mem_out_ready, exec_mem_in_ready, grant_id}), 0);
        stray = 1'b0;
        repeat (2) @(negedge clk);

        // reset asserted while an exec load is stalled
        @(posedge clk);
        #1;
        mem_delay = 10;
        mem_data  = 32'hFEED_0001;
        exec_mem_out_valid = 1'b1;
        exec_mem_out_addr  = 32'h5000;
        push_exp(2, 32'h5000, 32'hFEED_0001);
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("pre_reset_grant", 32'(grant_id), 2);
        #1;
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_valids", 32'({main_mem_out_valid, main_mem_in_valid}), 0);
        chk("async_rst_readies", 32'({fetch_mem_out_ready, exec_mem_out_ready, exec_mem_in_ready}), 0);
        chk("async_rst_grant", 32'(grant_id), 0);
        exec_mem_out_valid = 1'b0;
        model_last = 2;
        mem_delay  = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(grant_id), 0);
        run_vec(post_vec, 9);
        repeat (3) @(negedge clk);
        chk("final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Shares the single main-memory port between the instruction-fetch unit (load only) and the memory execution element (load and store). The block accepts one request at a time, chooses a winner with round-robin between the two requesters, and latches the address and data. It drives the downstream `main_mem_out_*` (load) and `main_mem_in_*` (store) channels and routes the completion back to the winner. It sits between the core's fetch and exec stages and the memory controller.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low; asserted while 0.
- `fetch_mem_out_addr`  in  ADDR_W  fetch load address.
- `fetch_mem_out_valid`  in  1  fetch load request.
- `fetch_mem_out_ready`  out  1  fetch load completes this cycle.
- `fetch_mem_out_data`  out  DATA_W  fetch load data; valid when ready=1.
- `exec_mem_out_addr` / `exec_mem_out_valid` / `exec_mem_out_ready` / `exec_mem_out_data`: exec load channel, same semantics as the fetch load channel.
- `exec_mem_in_addr`  in  ADDR_W  exec store address.
- `exec_mem_in_data`  in  DATA_W  exec store data.
- `exec_mem_in_valid`  in  1  exec store request.
- `exec_mem_in_ready`  out  1  exec store completes this cycle.
- `main_mem_out_addr` / `main_mem_out_valid`  out  ADDR_W / 1  downstream load request.
- `main_mem_out_ready` / `main_mem_out_data`  in  1 / DATA_W  downstream load completion and data.
- `main_mem_in_addr` / `main_mem_in_data` / `main_mem_in_valid`  out  ADDR_W / DATA_W / 1  downstream store.
- `main_mem_in_ready`  in  1  downstream store completion.
- `grant_id`  out  2  current owner: 0 none, 1 fetch, 2 exec.

## Operation
- Transaction completes on the cycle where valid and ready are both 1 on a channel.
- Requester rule: valid, address and data are held stable until that requester's ready pulse. Withdrawing them early is illegal; the arbiter uses its latched copy regardless.
- FSM states: `IDLE`, `FETCH_LD`, `EXEC_LD`, `EXEC_ST`.
- `IDLE`: sample the pending requests.
  - Exec store has priority over exec load when both are high.
  - Between fetch and exec, the winner is the requester that did not win last (`last_winner`).
  - If only one requester is pending, it wins.
  - Latch the winner's addr/data and go to the matching state. Remain in `IDLE` if nothing is pending.
- Grant states: the matching downstream valid is 1 and the latched addr/data drive the outputs.
  - On downstream ready: pulse the winner's ready for that same cycle, forward `main_mem_out_data` combinationally, update `last_winner`, return to `IDLE`.
- Non-winning ready outputs are always 0. The load data outputs are 0 when their ready is 0.
- `grant_id` follows the state.

## Timing
- Reset values:
  - State `IDLE`.
  - All valid/ready outputs 0; all addr/data outputs 0.
  - `grant_id` 0.
  - `last_winner` = exec, so fetch wins the first tie.
- Request visible at edge N → downstream valid from cycle N+1. If memory is ready in N+1, the requester's ready is 1 in N+1: minimum 2-cycle latency.
- After completion there is one `IDLE` cycle. Peak throughput is one transaction per 2 cycles.
- Downstream ready that is not coincident with the arbiter's own valid is ignored.
- Memory stall: the arbiter holds its grant indefinitely, with no timeout. The loser waits; its request is preserved by the requester hold rule.
- Reset mid-transaction: all valids drop immediately (asynchronous). The transaction is abandoned and not replayed. The memory side must tolerate valid deasserting.
- Simultaneous completion and new request: the new request is sampled in the following `IDLE` cycle, not the completing cycle.

## Structure
- Package `main_mem_arb_pkg`: state enum `arb_state_t`, requester id enum `arb_id_t` (NONE=0, FETCH=1, EXEC=2), width constants.
- One sub-module, `main_mem_arb_pick`: combinational 2-way round-robin picker with inputs (fetch_req, exec_req, last_winner) and output winner id.
- The top level holds the FSM, the latches and the routing.

## Test plan
- Fetch only, load addr 0x1000; memory ready 1 in the first grant cycle, data 0xDEADBEEF → `main_mem_out_addr`=0x1000 in cycle N+1; `fetch_mem_out_ready`=1 with data 0xDEADBEEF in N+1; exec ready stays 0.
- Exec store only, addr 0x10f4 data 12345678 → `main_mem_in_addr`=0x10f4, `main_mem_in_data`=12345678, `main_mem_in_valid`=1 until `main_mem_in_ready`; `exec_mem_in_ready` pulses once.
- Fetch and exec load requests high continuously, memory always ready → grants alternate fetch, exec, fetch, exec (fetch first after reset); `grant_id` sequence 1,0,2,0,1,…
- Exec load and store both valid → store granted first, then load. Memory ready delayed 3 cycles → valid held 3 cycles, addr stable.
- Reset driven to 0 during `EXEC_LD` → all valids and readies 0 immediately; after release, state `IDLE` and `grant_id`=0; a pending fetch is granted first.
